xbus_decoder: RTL and testbench

Parametrised, handshaked address decoder for the picoversat data bus. It routes one master request to one of N_SLV slave regions, each defined by a base address and an offset width. It waits for the selected slave's ready, registers the read data and returns a one-cycle ack. Unmapped addresses and (optionally) unresponsive slaves produce an error ack plus a trap pulse.

---
 rtl/xbus_decoder_pkg.sv | 20 ++
 rtl/xbus_region_match.sv | 36 +++
 rtl/xbus_decoder.sv | 169 ++++++++++++++++
 tb/tb_xbus_decoder.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/xbus_decoder_pkg.sv
// Shared definitions for the xbus address decoder: FSM state encoding,
// default bus widths and the slave-index width helper.
package xbus_decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_RESP = 2'd2
    } xbus_state_t;

    localparam int XBUS_DEF_ADDR_W  = 12;
    localparam int XBUS_DEF_DATA_W  = 32;
    localparam int XBUS_AW_FIELD_W  = 5;

    // A single slave still needs a one-bit index register.
    function automatic int xbus_idx_w(input int n_slv);
        return (n_slv > 1) ? $clog2(n_slv) : 1;
    endfunction

endpackage

// File: rtl/xbus_region_match.sv
// Combinational region decoder: raw per-slave hit vector, any-hit flag and
// the index of the lowest-numbered matching slave.
module xbus_region_match
    import xbus_decoder_pkg::*;
#(
    parameter int                                 ADDR_W   = XBUS_DEF_ADDR_W,
    parameter int                                 N_SLV    = 4,
    parameter logic [N_SLV*ADDR_W-1:0]            SLV_BASE = '0,
    parameter logic [N_SLV*XBUS_AW_FIELD_W-1:0]   SLV_AW   = '0,
    parameter int                                 IDX_W    = xbus_idx_w(N_SLV)
)(
    input  logic [ADDR_W-1:0] i_addr,
    output logic [N_SLV-1:0]  o_hit_vec,
    output logic [IDX_W-1:0]  o_idx,
    output logic              o_hit
);

    for (genvar g = 0; g < N_SLV; g++) begin : g_region
        localparam int AW_G = int'(SLV_AW[g*XBUS_AW_FIELD_W +: XBUS_AW_FIELD_W]);
        localparam logic [ADDR_W-1:0] MASK_G = {ADDR_W{1'b1}} << AW_G;
        assign o_hit_vec[g] = ((i_addr & MASK_G) == SLV_BASE[g*ADDR_W +: ADDR_W]);
    end

    // Scan from the top down so the lowest matching index is written last.
    always_comb begin
        o_idx = '0;
        for (int i = N_SLV - 1; i >= 0; i--) begin
            if (o_hit_vec[i]) begin
                o_idx = IDX_W'(i);
            end
        end
    end

    assign o_hit = |o_hit_vec;

endmodule

// File: rtl/xbus_decoder.sv
// Handshaked picoversat data-bus decoder with registered response.
// Optional XBUS_TIMEOUT_EN adds the ACC timeout counter and its error path.
//
//   state   | meaning
//   IDLE    | waiting for a master request
//   ACC     | slave selected, waiting for its ready (or timeout)
//   RESP    | one-cycle ack with err/rdata valid; request ignored
module xbus_decoder
    import xbus_decoder_pkg::*;
#(
    parameter int                                 ADDR_W   = XBUS_DEF_ADDR_W,
    parameter int                                 DATA_W   = XBUS_DEF_DATA_W,
    parameter int                                 N_SLV    = 4,
    parameter logic [N_SLV*ADDR_W-1:0]            SLV_BASE = {12'hC00, 12'h800, 12'h400, 12'h000},
    parameter logic [N_SLV*XBUS_AW_FIELD_W-1:0]   SLV_AW   = {5'd10, 5'd10, 5'd10, 5'd10},
    parameter int                                 TIMEOUT  = 16
)(
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_m_req,
    input  logic [ADDR_W-1:0]       i_m_addr,
    output logic                    o_m_ack,
    output logic                    o_m_err,
    output logic [DATA_W-1:0]       o_m_rdata,
    output logic                    o_busy,
    output logic [N_SLV-1:0]        o_slv_sel,
    input  logic [N_SLV-1:0]        i_slv_ready,
    input  logic [N_SLV*DATA_W-1:0] i_slv_rdata,
    output logic                    o_trap
);

    localparam int IDX_W = xbus_idx_w(N_SLV);

    if (N_SLV < 1 || N_SLV > 16) begin : g_bad_n_slv
        $error("xbus_decoder: N_SLV must be in 1..16");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("xbus_decoder: TIMEOUT must be at least 2");
    end

    xbus_state_t         r_state;
    logic [IDX_W-1:0]    r_idx;
    logic [N_SLV-1:0]    r_slv_sel;
    logic                r_ack;
    logic                r_err;
    logic                r_trap;
    logic                r_busy;
    logic [DATA_W-1:0]   r_rdata;

    logic [N_SLV-1:0]    w_hit_vec;
    logic [N_SLV-1:0]    w_first_oh;
    logic [IDX_W-1:0]    w_idx;
    logic                w_hit;
    logic                w_rdy_sel;
    logic [DATA_W-1:0]   w_rdata_sel;
    logic                w_timeout;

    xbus_region_match #(
        .ADDR_W   (ADDR_W),
        .N_SLV    (N_SLV),
        .SLV_BASE (SLV_BASE),
        .SLV_AW   (SLV_AW),
        .IDX_W    (IDX_W)
    ) u_match (
        .i_addr    (i_m_addr),
        .o_hit_vec (w_hit_vec),
        .o_idx     (w_idx),
        .o_hit     (w_hit)
    );

    // Isolate the lowest set hit bit so the select matches the encoded index.
    assign w_first_oh = w_hit_vec & ~(w_hit_vec - N_SLV'(1));

    always_comb begin
        w_rdy_sel   = 1'b0;
        w_rdata_sel = '0;
        for (int i = 0; i < N_SLV; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_rdy_sel   = i_slv_ready[i];
                w_rdata_sel = i_slv_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef XBUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] r_cnt;
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_slv_sel <= '0;
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
            r_trap    <= 1'b0;
            r_busy    <= 1'b0;
            r_rdata   <= '0;
`ifdef XBUS_TIMEOUT_EN
            r_cnt     <= '0;
`endif
        end else begin
            r_ack  <= 1'b0;
            r_trap <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_m_req) begin
                        r_busy <= 1'b1;
                        if (w_hit) begin
                            r_idx     <= w_idx;
                            r_slv_sel <= w_first_oh;
                            r_state   <= ST_ACC;
                        end else begin
                            r_ack   <= 1'b1;
                            r_err   <= 1'b1;
                            r_trap  <= 1'b1;
                            r_rdata <= '0;
                            r_state <= ST_RESP;
                        end
                    end
                end
                ST_ACC: begin
`ifdef XBUS_TIMEOUT_EN
                    r_cnt <= r_cnt + CNT_W'(1);
`endif
                    // Ready is checked first so a same-cycle timeout loses.
                    if (w_rdy_sel) begin
                        r_rdata   <= w_rdata_sel;
                        r_err     <= 1'b0;
                        r_ack     <= 1'b1;
                        r_slv_sel <= '0;
                        r_state   <= ST_RESP;
                    end else if (w_timeout) begin
                        r_rdata   <= '0;
                        r_err     <= 1'b1;
                        r_trap    <= 1'b1;
                        r_ack     <= 1'b1;
                        r_slv_sel <= '0;
                        r_state   <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
`ifdef XBUS_TIMEOUT_EN
                    r_cnt   <= '0;
`endif
                end
                default: begin
                    r_busy    <= 1'b0;
                    r_slv_sel <= '0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_m_ack   = r_ack;
    assign o_m_err   = r_err;
    assign o_m_rdata = r_rdata;
    assign o_busy    = r_busy;
    assign o_slv_sel = r_slv_sel;
    assign o_trap    = r_trap;

endmodule

// File: tb/tb_xbus_decoder.sv
// Self-checking bench for xbus_decoder: vector table, hand-written corner
// sequences and random transfers against an address-range reference model.
module tb_xbus_decoder;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int NS = 4;
    localparam int TO = 16;

    localparam logic [NS*AW-1:0] BASES  = {12'hC00, 12'h800, 12'h400, 12'h000};
    localparam logic [NS*5-1:0]  AWS    = {5'd8, 5'd10, 5'd10, 5'd10};
    localparam logic [2*AW-1:0]  BASES2 = {12'h400, 12'h000};
    localparam logic [2*5-1:0]   AWS2   = {5'd10, 5'd11};

`ifdef XBUS_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    logic              clk, rst;
    logic              m_req;
    logic [AW-1:0]     m_addr;
    logic              m_ack, m_err, busy, trap;
    logic [DW-1:0]     m_rdata;
    logic [NS-1:0]     slv_sel, slv_ready;
    logic [NS*DW-1:0]  slv_rdata;

    logic              req2, ack2, err2, busy2, trap2;
    logic [AW-1:0]     addr2;
    logic [DW-1:0]     rdata2;
    logic [1:0]        sel2, rdy2;
    logic [2*DW-1:0]   sdata2;

    int                total = 0;
    int                bad   = 0;
    logic [DW-1:0]     last_rdata;

    int                base_m[NS] = '{'h000, 'h400, 'h800, 'hC00};
    int                aw_m[NS]   = '{10, 10, 10, 8};

    typedef struct {
        int   addr;
        int   dly;
        int   idx;
        int   ack;
        logic err;
    } vec_t;
    vec_t tbl[8];

    xbus_decoder #(
        .ADDR_W(AW), .DATA_W(DW), .N_SLV(NS),
        .SLV_BASE(BASES), .SLV_AW(AWS), .TIMEOUT(TO)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_m_req(m_req), .i_m_addr(m_addr),
        .o_m_ack(m_ack), .o_m_err(m_err), .o_m_rdata(m_rdata), .o_busy(busy),
        .o_slv_sel(slv_sel), .i_slv_ready(slv_ready), .i_slv_rdata(slv_rdata),
        .o_trap(trap)
    );

    xbus_decoder #(
        .ADDR_W(AW), .DATA_W(DW), .N_SLV(2),
        .SLV_BASE(BASES2), .SLV_AW(AWS2), .TIMEOUT(TO)
    ) dut_ovl (
        .i_clk(clk), .i_rst(rst), .i_m_req(req2), .i_m_addr(addr2),
        .o_m_ack(ack2), .o_m_err(err2), .o_m_rdata(rdata2), .o_busy(busy2),
        .o_slv_sel(sel2), .i_slv_ready(rdy2), .i_slv_rdata(sdata2),
        .o_trap(trap2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    // Region i owns the address range [base, base + 2**aw); lowest index wins.
    function automatic int ref_idx(input int a);
        for (int i = 0; i < NS; i++) begin
            if (a >= base_m[i] && a < base_m[i] + (1 << aw_m[i])) return i;
        end
        return -1;
    endfunction

    // dly: ready arrives dly cycles after the select first appears (-1 = never).
    function automatic void ref_resp(input int idx, input int dly, output int ack, output logic err);
        if (idx < 0) begin
            ack = 1; err = 1'b1;
        end else if (TMO_ON && (dly < 0 || dly + 1 > TO)) begin
            ack = TO + 1; err = 1'b1;
        end else if (dly < 0) begin
            ack = -1; err = 1'b0;
        end else begin
            ack = dly + 2; err = 1'b0;
        end
    endfunction

    task automatic txn(input string nm, input int addr, input int dly, input int exp_idx,
                       input int exp_ack, input logic exp_err, input int limit);
        logic [NS-1:0] exp_sel;
        logic [DW-1:0] cap;
        logic          ack_now;
        cap     = '0;
        exp_sel = (exp_idx >= 0) ? NS'(1 << exp_idx) : '0;
        @(posedge clk); #1;
        chk({nm, " idle_busy"}, busy, 1'b0);
        chk({nm, " idle_ack"}, m_ack, 1'b0);
        chk({nm, " idle_sel"}, slv_sel, '0);
        m_req  = 1'b1;
        m_addr = addr[AW-1:0];
        slv_ready = NS'($urandom()) & ~exp_sel;
        for (int c = 1; c <= limit; c++) begin
            @(posedge clk); #1;
            ack_now = (c == exp_ack);
            chk({nm, " ack"}, m_ack, ack_now);
            chk({nm, " busy"}, busy, 1'b1);
            chk({nm, " sel"}, slv_sel, (exp_ack < 0 || c < exp_ack) ? exp_sel : '0);
            chk({nm, " trap"}, trap, ack_now && exp_err);
            if (ack_now) begin
                chk({nm, " err"}, m_err, exp_err);
                chk({nm, " rdata"}, m_rdata, exp_err ? '0 : cap);
                last_rdata = exp_err ? '0 : cap;
                m_req     = 1'b0;
                slv_ready = '0;
                break;
            end
            chk({nm, " rdata_hold"}, m_rdata, last_rdata);
            for (int i = 0; i < NS; i++) slv_rdata[i*DW +: DW] = $urandom();
            slv_ready = NS'($urandom()) & ~exp_sel;
            if (exp_idx >= 0 && c == dly + 1) begin
                slv_ready[exp_idx] = 1'b1;
                cap = slv_rdata[exp_idx*DW +: DW];
            end
        end
    endtask

    task automatic reset_abort();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid ack", m_ack, 1'b0);
        chk("rst_mid busy", busy, 1'b0);
        chk("rst_mid sel", slv_sel, '0);
        chk("rst_mid rdata", m_rdata, '0);
        chk("rst_mid err", m_err, 1'b0);
        chk("rst_mid trap", trap, 1'b0);
        m_req     = 1'b0;
        slv_ready = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        last_rdata = '0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            chk("post_rst no_ack", m_ack, 1'b0);
            chk("post_rst idle", busy, 1'b0);
        end
    endtask

    task automatic ovl(input string nm, input int a, input logic [1:0] exp_sel,
                       input logic exp_err, input logic [DW-1:0] exp_data);
        @(posedge clk); #1;
        req2  = 1'b1;
        addr2 = a[AW-1:0];
        @(posedge clk); #1;
        if (exp_err) begin
            chk({nm, " ack"}, ack2, 1'b1);
            chk({nm, " err"}, err2, 1'b1);
            chk({nm, " trap"}, trap2, 1'b1);
            chk({nm, " sel"}, sel2, 2'b00);
            chk({nm, " rdata"}, rdata2, '0);
            req2 = 1'b0;
        end else begin
            chk({nm, " sel"}, sel2, exp_sel);
            chk({nm, " early_ack"}, ack2, 1'b0);
            @(posedge clk); #1;
            chk({nm, " ack"}, ack2, 1'b1);
            chk({nm, " err"}, err2, 1'b0);
            chk({nm, " rdata"}, rdata2, exp_data);
            req2 = 1'b0;
        end
        @(posedge clk);
    endtask

    initial begin
        int   a, d, idx, ack;
        logic err;

        tbl[0] = '{'h405, 0,      1,  2,      1'b0};
        tbl[1] = '{'h8AB, 5,      2,  7,      1'b0};
        tbl[2] = '{'hD00, 0,      -1, 1,      1'b1};
        tbl[3] = '{'hCFF, 1,      3,  3,      1'b0};
        tbl[4] = '{'h000, 2,      0,  4,      1'b0};
        tbl[5] = '{'hFFF, 0,      -1, 1,      1'b1};
        tbl[6] = '{'h3FF, TO - 1, 0,  TO + 1, 1'b0};
        tbl[7] = '{'hBFF, 0,      2,  2,      1'b0};

        rst        = 1'b1;
        m_req      = 1'b0;
        m_addr     = '0;
        slv_ready  = '0;
        slv_rdata  = '0;
        req2       = 1'b0;
        addr2      = '0;
        rdy2       = 2'b11;
        sdata2     = {32'hB1B1_B1B1, 32'hA0A0_A0A0};
        last_rdata = '0;

        #12;
        chk("reset ack", m_ack, 1'b0);
        chk("reset err", m_err, 1'b0);
        chk("reset trap", trap, 1'b0);
        chk("reset busy", busy, 1'b0);
        chk("reset sel", slv_sel, '0);
        chk("reset rdata", m_rdata, '0);
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 8; k++) begin
            txn($sformatf("vec%0d", k), tbl[k].addr, tbl[k].dly, tbl[k].idx,
                tbl[k].ack, tbl[k].err, 40);
        end

        ovl("ovl_480", 'h480, 2'b01, 1'b0, 32'hA0A0_A0A0);
        ovl("ovl_7ff", 'h7FF, 2'b01, 1'b0, 32'hA0A0_A0A0);
        ovl("ovl_a00", 'hA00, 2'b00, 1'b1, 32'h0);

        for (int k = 0; k < 40; k++) begin
            a   = int'($urandom_range(0, 4095));
            d   = int'($urandom_range(0, 20));
            idx = ref_idx(a);
            ref_resp(idx, d, ack, err);
            txn($sformatf("rnd%0d", k), a, d, idx, ack, err, 40);
        end

`ifdef XBUS_TIMEOUT_EN
        txn("timeout", 'h010, -1, 0, TO + 1, 1'b1, TO + 5);
`endif
        txn("pre_rst", 'h805, 1, 2, 3, 1'b0, 40);
`ifdef XBUS_TIMEOUT_EN
        txn("rst_hold", 'h410, -1, 1, -1, 1'b0, 4);
`else
        txn("no_timeout", 'h010, -1, 0, -1, 1'b0, 100);
`endif
        reset_abort();
        txn("after_rst", 'h405, 0, 1, 2, 1'b0, 40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
